// File: rtl/step_dir_decoder.sv
// Step/dir receiver: synchronises and glitch-filters STP/DIR, counts steps into a
// signed position and measures the cycle distance between same-direction steps.
module step_dir_decoder #(
    parameter int unsigned FILTER_LEN = 4,
    parameter logic [31:0] TIMEOUT    = 32'd1000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               STP,
    input  logic               DIR,
    input  logic               load,
    input  logic signed [31:0] loadValue,
    output logic signed [31:0] jointFeedback,
    output logic        [31:0] stepPeriod,
    output logic               stepPulse,
    output logic               moving
);

    localparam logic [7:0] FILT_CMP = 8'(FILTER_LEN);

    // Channel 0 is STP, channel 1 is DIR; both get identical treatment.
    logic [1:0] raw_in;
    logic [1:0] filt_lvl;

    assign raw_in = {DIR, STP};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_chan
            logic       sync1_q, sync1_d;
            logic       sync2_q, sync2_d;
            logic       level_q, level_d;
            logic [7:0] cnt_q,   cnt_d;

            // A new level is accepted only after FILTER_LEN consecutive differing samples.
            always_comb begin
                sync1_d = raw_in[gi];
                sync2_d = sync1_q;
                level_d = level_q;
                cnt_d   = 8'd0;
                if (sync2_q != level_q) begin
                    if (cnt_q + 8'd1 == FILT_CMP) begin
                        level_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    level_q <= 1'b0;
                    cnt_q   <= 8'd0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    level_q <= level_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign filt_lvl[gi] = level_q;
        end
    endgenerate

    logic               stp_prev_q, stp_prev_d;
    logic               step_now;
    logic               step_dir;
    logic signed [31:0] pos_q,      pos_d;
    logic        [31:0] elapsed_q,  elapsed_d;
    logic        [31:0] period_q,   period_d;
    logic               pulse_q,    pulse_d;
    logic               moving_q,   moving_d;
    logic               last_dir_q, last_dir_d;

    assign step_now = filt_lvl[0] & ~stp_prev_q;
    assign step_dir = filt_lvl[1];

    always_comb begin
        stp_prev_d = filt_lvl[0];
        pulse_d    = step_now;

        pos_d = pos_q;
        if (load) begin
            pos_d = loadValue;
        end else if (step_now) begin
            pos_d = step_dir ? pos_q + 32'sd1 : pos_q - 32'sd1;
        end

        // Restarting at 1 makes elapsed equal the exact step distance at the next step.
        elapsed_d = elapsed_q;
        if (step_now) begin
            elapsed_d = 32'd1;
        end else if (elapsed_q < TIMEOUT) begin
            elapsed_d = elapsed_q + 32'd1;
        end

        period_d   = period_q;
        moving_d   = moving_q;
        last_dir_d = last_dir_q;
        if (step_now) begin
            last_dir_d = step_dir;
            moving_d   = 1'b1;
            if (moving_q && (step_dir == last_dir_q)) begin
                period_d = elapsed_q;
            end else begin
                period_d = 32'd0;
            end
        end else if (elapsed_q >= TIMEOUT) begin
            moving_d = 1'b0;
            period_d = 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stp_prev_q <= 1'b0;
            pos_q      <= 32'sd0;
            elapsed_q  <= 32'd0;
            period_q   <= 32'd0;
            pulse_q    <= 1'b0;
            moving_q   <= 1'b0;
            last_dir_q <= 1'b0;
        end else begin
            stp_prev_q <= stp_prev_d;
            pos_q      <= pos_d;
            elapsed_q  <= elapsed_d;
            period_q   <= period_d;
            pulse_q    <= pulse_d;
            moving_q   <= moving_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign jointFeedback = pos_q;
    assign stepPeriod    = period_q;
    assign stepPulse     = pulse_q;
    assign moving        = moving_q;

endmodule

// File: tb/tb_step_dir_decoder.sv
// Scoreboard bench for step_dir_decoder: the stimulus thread predicts each step from
// rise times and direction, the negedge monitor checks every stepPulse against it.
`timescale 1ns/1ps
module tb_step_dir_decoder;

    localparam int L  = 4;
    localparam int TO = 100;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        STP       = 1'b0;
    logic        DIR       = 1'b0;
    logic        load      = 1'b0;
    logic [31:0] loadValue = 32'd0;
    logic [31:0] jointFeedback;
    logic [31:0] stepPeriod;
    logic        stepPulse;
    logic        moving;

    step_dir_decoder #(.FILTER_LEN(L), .TIMEOUT(32'(TO))) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .STP          (STP),
        .DIR          (DIR),
        .load         (load),
        .loadValue    (loadValue),
        .jointFeedback(jointFeedback),
        .stepPeriod   (stepPeriod),
        .stepPulse    (stepPulse),
        .moving       (moving)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [31:0] pos;
        logic [31:0] per;
        logic [31:0] mov;
    } exp_t;

    exp_t q[$];

    int errors = 0;
    int checks = 0;

    // Reference model state: position plus time/direction of the previous step.
    logic [31:0] m_pos      = 32'd0;
    int unsigned m_last_cyc = 0;
    bit          m_last_dir = 1'b0;
    bit          m_have_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called in the cycle STP is driven high: a step lands L+3 edges later.
    task automatic issue_step(input bit dir, input bit ld, input logic [31:0] lv);
        exp_t        e;
        int unsigned gap;
        e.cyc = cyc + L + 3;
        gap   = e.cyc - m_last_cyc;
        if (m_have_prev && gap <= TO && dir == m_last_dir) e.per = gap;
        else e.per = 32'd0;
        m_pos = ld ? lv : (dir ? m_pos + 32'd1 : m_pos - 32'd1);
        e.pos = m_pos;
        e.mov = 32'd1;
        m_last_cyc  = e.cyc;
        m_last_dir  = dir;
        m_have_prev = 1'b1;
        q.push_back(e);
    endtask

    // glitch: 0 none, 1 short STP pulse, 2 short DIR pulse, placed inside the low phase.
    task automatic pulse(input bit dir, input int lo, input int hi, input int glitch,
                         input int g, input bit ld, input logic [31:0] lv);
        int h;
        h   = (ld && hi < L + 4) ? L + 4 : hi;
        DIR = dir;
        if (glitch == 1 && lo >= L + 3 + g + 2) begin
            tick(L + 3); STP = 1'b1; tick(g); STP = 1'b0; tick(lo - L - 3 - g);
        end else if (glitch == 2 && lo >= L + 3 + g + 2) begin
            tick(L + 3); DIR = ~dir; tick(g); DIR = dir; tick(lo - L - 3 - g);
        end else begin
            tick(lo);
        end
        STP = 1'b1;
        issue_step(dir, ld, lv);
        if (ld) begin
            tick(L + 2);
            loadValue = lv;
            load      = 1'b1;
            tick(1);
            load      = 1'b0;
            tick(h - L - 3);
        end else begin
            tick(h);
        end
        STP = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        chk("drain_pending", 32'(q.size()), 32'd0);
        tick(1);
    endtask

    task automatic do_load(input logic [31:0] v);
        loadValue = v;
        load      = 1'b1;
        tick(1);
        load      = 1'b0;
        m_pos     = v;
        chk("load_value", jointFeedback, v);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_pos"},    jointFeedback, 32'd0);
        chk({tag, "_period"}, stepPeriod,    32'd0);
        chk({tag, "_pulse"},  {31'd0, stepPulse}, 32'd0);
        chk({tag, "_moving"}, {31'd0, moving},    32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && stepPulse) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_step: stepPulse=1 at cycle %0d, required no step", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("step cyc=%0d pos=0x%08h period=%0d moving=%0b", cyc, jointFeedback, stepPeriod, moving);
                chk("step_cycle",  cyc,              e.cyc);
                chk("step_pos",    jointFeedback,    e.pos);
                chk("step_period", stepPeriod,       e.per);
                chk("step_moving", {31'd0, moving},  e.mov);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        bit          dir_r;
        int          lo, hi, gl, g;
        bit          ld;
        logic [31:0] lv;
        int          n;

        // Reset with activity on the inputs.
        for (int i = 0; i < 5; i++) begin
            STP = 1'($urandom);
            DIR = 1'($urandom);
            tick(1);
        end
        chk_idle("reset");
        STP   = 1'b0;
        DIR   = 1'b0;
        rst_n = 1'b1;
        tick(12);
        chk_idle("post_reset");

        // Forward train at period 16.
        for (int i = 0; i < 10; i++) pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        drain();
        chk("fwd_pos",    jointFeedback, 32'd10);
        chk("fwd_period", stepPeriod,    32'd16);
        chk("fwd_moving", {31'd0, moving}, 32'd1);

        // Sub-threshold glitches on both inputs.
        tick(L + 2);
        STP = 1'b1; tick(3); STP = 1'b0; tick(4);
        DIR = ~DIR; tick(3); DIR = ~DIR; tick(L + 6);
        chk("glitch_pos",    jointFeedback, 32'd10);
        chk("glitch_moving", {31'd0, moving}, 32'd1);

        // Reversal at period 20.
        do_load(32'd0);
        for (int i = 0; i < 5; i++) pulse(1'b1, 10, 10, 0, 0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) pulse(1'b0, 10, 10, 0, 0, 1'b0, 32'd0);
        drain();
        chk("rev_pos", jointFeedback, 32'd2);

        // Timeout exactly TO cycles after the last step.
        for (int i = 0; i < 3; i++) pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        n = int'(m_last_cyc) + TO - 1 - int'(cyc);
        tick(n);
        chk("pre_timeout_moving", {31'd0, moving}, 32'd1);
        chk("pre_timeout_period", stepPeriod,      32'd16);
        tick(1);
        chk("timeout_moving", {31'd0, moving}, 32'd0);
        chk("timeout_period", stepPeriod,      32'd0);
        pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        pulse(1'b1, 92, 8, 0, 0, 1'b0, 32'd0);   // gap of exactly TO
        pulse(1'b1, 93, 8, 0, 0, 1'b0, 32'd0);   // gap of TO+1
        pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        drain();

        // Load and two's-complement wrap in both directions.
        do_load(32'h7FFF_FFFF);
        pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        drain();
        chk("wrap_up", jointFeedback, 32'h8000_0000);
        pulse(1'b0, 8, 8, 0, 0, 1'b0, 32'd0);
        drain();
        chk("wrap_down", jointFeedback, 32'h7FFF_FFFF);
        pulse(1'b1, 8, 10, 0, 0, 1'b1, 32'd5);
        drain();
        chk("load_on_step", jointFeedback, 32'd5);

        // Randomised trains with glitches, reversals, timeouts and coincident loads.
        dir_r = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) == 0) dir_r = ~dir_r;
            lo = ($urandom_range(0, 9) == 0) ? int'($urandom_range(88, 100))
                                            : int'($urandom_range(L, L + 12));
            hi = int'($urandom_range(L, L + 6));
            gl = int'($urandom_range(0, 5));
            gl = (gl > 2) ? 0 : gl;
            g  = int'($urandom_range(1, L - 1));
            if (gl != 0 && lo < L + 3 + g + 2) lo = L + 3 + g + 2;
            ld = ($urandom_range(0, 9) == 0);
            lv = $urandom;
            pulse(dir_r, lo, hi, gl, g, ld, lv);
        end
        drain();
        chk("rand_final_pos", jointFeedback, m_pos);

        // Reset while a step is still inside the filter.
        STP = 1'b1;
        tick(3);
        rst_n = 1'b0;
        tick(2);
        STP   = 1'b0;
        rst_n = 1'b1;
        m_have_prev = 1'b0;
        m_pos       = 32'd0;
        tick(15);
        chk_idle("mid_reset");
        pulse(1'b1, 8, 8, 0, 0, 1'b0, 32'd0);
        drain();
        chk("after_reset_pos", jointFeedback, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
